// File: rtl/t10_uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver: the common
// state typedef, data width, default baud divider and a parity helper.
package t10_uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int UART_CLKS_PER_BAUD = 1041;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/t10_uart_rx_sync2.sv
// Two-flop synchroniser for a single asynchronous input. RST_VAL sets the
// value both flops take in reset so an idle-high line looks idle from the start.
module t10_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/t10_uart_rx.sv
// UART 8-N-1 receiver. Synchronises the line, detects a start bit, samples
// each bit at mid-bit and hands bytes over through a valid/ack holding
// register with framing and overrun status.
// Optional build macro T10_UART_RX_PARITY_EN adds an even-parity bit after
// D7 (11-bit frame) and drives parity_err; otherwise parity_err is tied 0.
//
// state  | meaning
// IDLE   | line idle, waiting for sync_rx low
// START  | half a bit into the start bit, confirm it is still low
// DATA   | sample D0..D7 at mid-bit, LSB first
// PARITY | sample the even-parity bit (parity build only)
// STOP   | sample the stop bit, complete the frame, return to IDLE
module t10_uart_rx
    import t10_uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD = UART_CLKS_PER_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(CLKS_PER_BAUD);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BAUD - 1);

    logic                      sync_rx;
    uart_state_t               state, state_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;
    logic [2:0]                bit_idx, bit_idx_nxt;
    logic [UART_DATA_BITS-1:0] shift, shift_nxt;
    logic                      half_tick;
    logic                      baud_tick;
    logic                      done;
    logic                      frame_fe;
`ifdef T10_UART_RX_PARITY_EN
    logic                      par_bit, par_bit_nxt;
    logic                      frame_pe;
`endif

    t10_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_serial),
        .q   (sync_rx)
    );

    assign half_tick = (cnt == HALF_LAST);
    assign baud_tick = (cnt == BAUD_LAST);
    assign frame_fe  = ~sync_rx;

    // FSM and frame datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef T10_UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
`ifdef T10_UART_RX_PARITY_EN
            par_bit <= par_bit_nxt;
`endif
        end
    end

    // Next state, baud counting and bit capture; done flags the stop sample.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        done        = 1'b0;
`ifdef T10_UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
`endif
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!sync_rx) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_tick) begin
                    cnt_nxt = '0;
                    if (!sync_rx) begin
                        bit_idx_nxt = '0;
                        state_nxt   = DATA;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = sync_rx;
                    if (bit_idx == 3'd7) begin
`ifdef T10_UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef T10_UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tick) begin
                    cnt_nxt     = '0;
                    par_bit_nxt = sync_rx;
                    state_nxt   = STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (baud_tick) begin
                    // Leave mid-stop-bit so a back-to-back start edge is seen.
                    cnt_nxt   = '0;
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef T10_UART_RX_PARITY_EN
    assign frame_pe = (even_parity(shift) != par_bit);
`endif

    // Holding register: load on completion, drop and flag overrun when the
    // previous byte is still unconsumed, release on rx_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
`ifdef T10_UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else if (done) begin
            if (!rx_valid || rx_ack) begin
                rx_byte     <= shift;
                rx_valid    <= 1'b1;
                framing_err <= frame_fe;
`ifdef T10_UART_RX_PARITY_EN
                parity_err  <= frame_pe;
`endif
                // An ack in the same cycle consumed the old byte, so nothing
                // was lost.
                overrun     <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_ack && rx_valid) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

`ifndef T10_UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_t10_uart_rx.sv
// Self-checking bench for t10_uart_rx at 16 clocks per bit. Frames are
// driven at bit level; a frame-level model predicts the cycle each frame
// becomes visible and applies the holding-register rules, compared on
// every negative clock edge. Directed cases carry literal expectations.
module tb_t10_uart_rx;

    localparam int C    = 16;
    localparam int HALF = C / 2;
`ifdef T10_UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Drive cycle of the start edge to first cycle the result is visible:
    // 2 synchroniser cycles, half a bit, remaining bits to stop sample, +1.
    localparam int LAT  = 2 + HALF + (FRAME_BITS - 1) * C + 1;
    localparam int MAXC = 40000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_serial = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;
    logic       parity_err;

    t10_uart_rx #(
        .CLKS_PER_BAUD (C)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_serial   (rx_serial),
        .rx_ack      (rx_ack),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .framing_err (framing_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rise_cyc = -1;
    bit prev_valid = 1'b0;

    bit         comp_at   [MAXC];
    logic [7:0] comp_byte [MAXC];
    bit         comp_fe   [MAXC];
    bit         comp_pe   [MAXC];
    bit         ack_sched [MAXC];

    logic [7:0] m_byte = 8'h00;
    bit m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;
    bit e_ack;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        m_byte  = 8'h00;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        m_pe    = 1'b0;
    endtask

    // Frame-level model update at each rising edge, then drive scheduled acks.
    always @(posedge clk) begin
        e_ack = rx_ack;
        cyc++;
        if (rst) begin
            model_clear();
        end else if (cyc < MAXC) begin
            if (comp_at[cyc]) begin
                if (!m_valid || e_ack) begin
                    m_byte  = comp_byte[cyc];
                    m_valid = 1'b1;
                    m_fe    = comp_fe[cyc];
                    m_pe    = comp_pe[cyc];
                    m_ov    = 1'b0;
                end else begin
                    m_ov = 1'b1;
                end
            end else if (e_ack && m_valid) begin
                m_valid = 1'b0;
                m_ov    = 1'b0;
            end
        end
        #1;
        rx_ack = (cyc < MAXC) ? ack_sched[cyc] : 1'b0;
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (rst) model_clear();
        check("rx_byte",     int'(rx_byte),     int'(m_byte));
        check("rx_valid",    int'(rx_valid),    int'(m_valid));
        check("framing_err", int'(framing_err), int'(m_fe));
        check("overrun",     int'(overrun),     int'(m_ov));
        check("parity_err",  int'(parity_err),  int'(m_pe));
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation did not finish within %0d cycles", MAXC);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame starting this cycle and record its predicted outcome.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                              input int gap_bits, input bit ack_done, output int start);
        int t;
        start = cyc;
        t = cyc + LAT;
        if (t < MAXC) begin
            comp_at[t]   = 1'b1;
            comp_byte[t] = b;
            comp_fe[t]   = !stop_ok;
`ifdef T10_UART_RX_PARITY_EN
            comp_pe[t]   = !par_ok;
`else
            comp_pe[t]   = 1'b0;
`endif
            if (ack_done) ack_sched[t - 1] = 1'b1;
        end
        rx_serial = 1'b0;
        step(C);
        for (int k = 0; k < 8; k++) begin
            rx_serial = b[k];
            step(C);
        end
`ifdef T10_UART_RX_PARITY_EN
        rx_serial = (^b) ^ !par_ok;
        step(C);
`endif
        rx_serial = stop_ok;
        step(C);
        rx_serial = 1'b1;
        step(gap_bits * C);
    endtask

    task automatic glitch(input int len);
        rx_serial = 1'b0;
        step(len);
        rx_serial = 1'b1;
        step(2 * C);
    endtask

    task automatic ack_now();
        ack_sched[cyc + 1] = 1'b1;
        step(2);
    endtask

    initial begin
        int n;
        logic [7:0] rb;
        bit rsok, rpok, rad;
        int rgap, nack, acyc;

        // Reset state
        step(5);
        check("reset_valid",    int'(rx_valid),    0);
        check("reset_byte",     int'(rx_byte),     0);
        check("reset_overrun",  int'(overrun),     0);
        check("reset_framing",  int'(framing_err), 0);
        check("reset_parity",   int'(parity_err),  0);
        rst = 1'b0;
        step(2 * C);

        // Good frame 0xA5, exact rise cycle, then ack
        send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0, n);
`ifdef T10_UART_RX_PARITY_EN
        check("a5_rise_cycle", rise_cyc, n + 2 + 8 + 145 + 16);
`else
        check("a5_rise_cycle", rise_cyc, n + 2 + 8 + 145);
`endif
        check("a5_byte",    int'(rx_byte),     8'hA5);
        check("a5_valid",   int'(rx_valid),    1);
        check("a5_framing", int'(framing_err), 0);
        ack_now();
        check("a5_ack_valid", int'(rx_valid), 0);

        // Short low glitch is rejected, next frame still aligns
        glitch(4);
        check("glitch_valid", int'(rx_valid), 0);
        send_frame(8'h3C, 1'b1, 1'b1, 1, 1'b0, n);
        check("3c_byte",  int'(rx_byte),  8'h3C);
        check("3c_valid", int'(rx_valid), 1);
        ack_now();

        // Low stop bit: byte delivered with framing_err, cleared by good frame
        send_frame(8'h81, 1'b0, 1'b1, 2, 1'b0, n);
        check("81_byte",    int'(rx_byte),     8'h81);
        check("81_valid",   int'(rx_valid),    1);
        check("81_framing", int'(framing_err), 1);
        ack_now();
        send_frame(8'h42, 1'b1, 1'b1, 1, 1'b0, n);
        check("42_framing", int'(framing_err), 0);
        check("42_byte",    int'(rx_byte),     8'h42);
        ack_now();

        // Back-to-back without ack: second frame dropped, overrun set
        send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0, n);
        send_frame(8'h22, 1'b1, 1'b1, 1, 1'b0, n);
        check("ovr_byte",    int'(rx_byte),  8'h11);
        check("ovr_overrun", int'(overrun),  1);
        ack_now();
        check("ovr_ack_valid",   int'(rx_valid), 0);
        check("ovr_ack_overrun", int'(overrun),  0);

        // Ack in the very completion cycle of the next frame
        send_frame(8'h33, 1'b1, 1'b1, 0, 1'b0, n);
        send_frame(8'h55, 1'b1, 1'b1, 1, 1'b1, n);
        check("same_cyc_byte",    int'(rx_byte),  8'h55);
        check("same_cyc_valid",   int'(rx_valid), 1);
        check("same_cyc_overrun", int'(overrun),  0);
        ack_now();

        // Reset mid-DATA while a flagged byte is held
        send_frame(8'h99, 1'b0, 1'b1, 2, 1'b0, n);
        rx_serial = 1'b0;
        step(C);
        for (int k = 0; k < 3; k++) begin
            rx_serial = k[0];
            step(C);
        end
        rst = 1'b1;
        #1;
        check("rst_mid_valid",   int'(rx_valid),    0);
        check("rst_mid_byte",    int'(rx_byte),     0);
        check("rst_mid_framing", int'(framing_err), 0);
        rx_serial = 1'b1;
        step(3);
        rst = 1'b0;
        step(2 * C);
        send_frame(8'hF0, 1'b1, 1'b1, 1, 1'b0, n);
        check("f0_byte",    int'(rx_byte),     8'hF0);
        check("f0_valid",   int'(rx_valid),    1);
        check("f0_framing", int'(framing_err), 0);
        ack_now();

        // Parity: 0x07 with parity bit 0 is a mismatch in the parity build
        send_frame(8'h07, 1'b1, 1'b0, 1, 1'b0, n);
        check("07_byte", int'(rx_byte), 8'h07);
`ifdef T10_UART_RX_PARITY_EN
        check("07_parity", int'(parity_err), 1);
`else
        check("07_parity", int'(parity_err), 0);
`endif
        ack_now();

        // Randomised frames, glitches and ack timing
        for (int i = 0; i < 60; i++) begin
            rb   = 8'($urandom);
            rsok = ($urandom_range(0, 7) != 0);
            rpok = ($urandom_range(0, 7) != 0);
            rgap = rsok ? int'($urandom_range(0, 2)) : 2;
            rad  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 5) == 0) glitch(int'($urandom_range(1, HALF - 1)));
            nack = int'($urandom_range(0, 2));
            for (int j = 0; j < nack; j++) begin
                acyc = cyc + int'($urandom_range(1, 10 * C));
                if (acyc < MAXC) ack_sched[acyc] = 1'b1;
            end
            send_frame(rb, rsok, rpok, rgap, rad, n);
        end
        step(2 * C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
